prt_dptx_trn_seq: RTL and testbench

- DP TX link pattern sequencer; sits directly upstream of the TX scrambler on each lane.
- Generates the training patterns TPS1 and TPS2 and the enhanced-framing idle pattern.
- Drives the scrambler enable and enhanced-framing controls so that training patterns pass unscrambled and the idle pattern is scrambled.
- Pattern changes occur only at legal pattern boundaries.

---
 rtl/prt_dptx_trn_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_prt_dptx_trn_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/prt_dptx_trn_seq.sv
// -----------------------------------------------------------------------------
// prt_dptx_trn_seq
// DisplayPort TX link pattern sequencer. It sits directly upstream of the TX
// scrambler on each lane.
//
// Patterns generated:
//   - TPS1 : continuous D10.2, unscrambled
//   - TPS2 : K28.5 D11.6 K28.5 D11.6 D10.2 x6, repeating every 10 symbols,
//            unscrambled
//   - IDLE : BS BF BF BS VB-ID Mvid Maud, then D0.0 up to the idle period,
//            scrambled
//
// Pipeline:
//   - The first register stage holds the mode and the symbol index.
//   - The second stage registers the symbols generated from the first stage.
//   - The scrambler enable is taken from the next-mode value. It therefore
//     leads the data it qualifies by one cycle, which matches the scrambler's
//     own one-cycle control register.
//
// Optional build macro:
//   PRT_DPTX_TRN_STAT_EN - adds STA_PER_CNT_OUT, a saturating count of
//                          completed IDLE periods.
// -----------------------------------------------------------------------------
module prt_dptx_trn_seq #(
  parameter int P_SIM = 0,  // 1: short idle period for simulation
  parameter int P_SPL = 2   // symbols per lane per clock (2 or 4)
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic                 CTL_EN_IN,
  input  logic [1:0]           CTL_TPS_IN,
  output logic                 SCRM_EN_OUT,
  output logic                 SCRM_EFM_OUT,
  output logic [P_SPL-1:0]     LNK_K_OUT,
  output logic [8*P_SPL-1:0]   LNK_DAT_OUT,
  output logic [1:0]           STA_MODE_OUT
`ifdef PRT_DPTX_TRN_STAT_EN
  ,
  output logic [15:0]          STA_PER_CNT_OUT
`endif
);

  // Idle period in symbols; always a multiple of P_SPL.
  localparam int unsigned P_PER      = (P_SIM != 0) ? 64 : 8192;
  localparam logic [12:0] C_SPL      = 13'(P_SPL);
  localparam logic [12:0] C_PER_LAST = 13'(P_PER - P_SPL);  // index of last group in a period
  localparam logic [12:0] C_TPS2_LEN = 13'd10;

  // Symbol codes.
  localparam logic [7:0] C_D10_2 = 8'h4A;
  localparam logic [7:0] C_D11_6 = 8'hCB;
  localparam logic [7:0] C_K28_5 = 8'hBC;  // also BS in IDLE
  localparam logic [7:0] C_BF    = 8'hF7;
  localparam logic [7:0] C_VBID  = 8'h08;  // NoVideoStream flag set

  // Encoding doubles as the STA_MODE_OUT value.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_TPS1 = 2'd1,
    MODE_TPS2 = 2'd2,
    MODE_IDLE = 2'd3
  } mode_e;

  mode_e       mode_q, mode_d;
  mode_e       req_mode;
  logic [12:0] sym_idx_q, sym_idx_d;
  logic [12:0] idx_inc;
  logic        tps2_bound;
  logic        tps2_wrap;
  logic        idle_wrap;

  logic               scrm_en_q;
  logic               scrm_efm_q;
  logic [P_SPL-1:0]   lnk_k_q;
  logic [8*P_SPL-1:0] lnk_dat_q;
  mode_e              sta_mode_q;

  logic [P_SPL-1:0]   pat_k;
  logic [8*P_SPL-1:0] pat_dat;

  // Map the pattern request onto a mode; the reserved code behaves as idle.
  always_comb begin
    unique case (CTL_TPS_IN)
      2'd1:    req_mode = MODE_TPS1;
      2'd2:    req_mode = MODE_TPS2;
      default: req_mode = MODE_IDLE;
    endcase
  end

  // Index of symbol 0 on the next cycle, before any wrap.
  assign idx_inc = sym_idx_q + C_SPL;

  // TPS2 holds its index modulo 10. The pattern may only be left when the
  // next cycle would start exactly on a new 10-symbol sequence.
  assign tps2_bound = (idx_inc == C_TPS2_LEN);
  assign tps2_wrap  = (idx_inc >= C_TPS2_LEN);

  // The last group of an idle period is being sent.
  assign idle_wrap = (sym_idx_q == C_PER_LAST);

  // Compute the next mode and symbol index. Entering any state restarts the
  // index at 0. A request equal to the current mode leaves the index running.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    mode_d    = mode_q;
    sym_idx_d = sym_idx_q;
    if (!CTL_EN_IN) begin
      mode_d    = MODE_OFF;
      sym_idx_d = '0;
    end else begin
      unique case (mode_q)
        MODE_OFF: begin
          mode_d    = req_mode;
          sym_idx_d = '0;
        end
        MODE_TPS1: begin
          if (req_mode != MODE_TPS1) begin
            mode_d    = req_mode;
            sym_idx_d = '0;
          end else begin
            sym_idx_d = idx_inc;
          end
        end
        MODE_TPS2: begin
          if (tps2_bound && (req_mode != MODE_TPS2)) begin
            mode_d    = req_mode;
            sym_idx_d = '0;
          end else if (tps2_wrap) begin
            sym_idx_d = idx_inc - C_TPS2_LEN;
          end else begin
            sym_idx_d = idx_inc;
          end
        end
        MODE_IDLE: begin
          if (req_mode != MODE_IDLE) begin
            mode_d    = req_mode;
            sym_idx_d = '0;
          end else if (idle_wrap) begin
            sym_idx_d = '0;
          end else begin
            sym_idx_d = idx_inc;
          end
        end
        default: begin
          mode_d    = MODE_OFF;
          sym_idx_d = '0;
        end
      endcase
    end
  end

  // Generate the symbols of the current mode; symbol i uses index sym_idx+i.
  always_comb begin
    logic [12:0] pos;
    logic [12:0] pos10;
    pat_k   = '0;
    pat_dat = '0;
    for (int i = 0; i < P_SPL; i++) begin
      pos   = sym_idx_q + 13'(i);
      pos10 = (pos >= C_TPS2_LEN) ? (pos - C_TPS2_LEN) : pos;
      unique case (mode_q)
        MODE_TPS1: begin
          pat_dat[8*i +: 8] = C_D10_2;
        end
        MODE_TPS2: begin
          if (pos10 < 13'd4) begin
            // Even positions carry K28.5, odd positions carry D11.6.
            pat_k[i]          = ~pos10[0];
            pat_dat[8*i +: 8] = pos10[0] ? C_D11_6 : C_K28_5;
          end else begin
            pat_dat[8*i +: 8] = C_D10_2;
          end
        end
        MODE_IDLE: begin
          unique case (pos)
            13'd0, 13'd3: begin
              pat_k[i]          = 1'b1;
              pat_dat[8*i +: 8] = C_K28_5;
            end
            13'd1, 13'd2: begin
              pat_k[i]          = 1'b1;
              pat_dat[8*i +: 8] = C_BF;
            end
            13'd4:   pat_dat[8*i +: 8] = C_VBID;
            default: pat_dat[8*i +: 8] = 8'h00;  // Mvid, Maud, D0.0 fill
          endcase
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PRT_DPTX_TRN_STAT_EN
  logic [15:0] per_cnt_q;
  logic        per_done;
  logic        idle_entry;

  // A full idle period completes on this cycle.
  assign per_done   = CTL_EN_IN && (mode_q == MODE_IDLE) && idle_wrap;
  assign idle_entry = (mode_q != MODE_IDLE) && (mode_d == MODE_IDLE);

  // Saturating count of completed idle periods; restarts with each idle entry.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN || !CTL_EN_IN || idle_entry) begin
      per_cnt_q <= '0;
    end else if (per_done && (per_cnt_q != 16'hFFFF)) begin
      per_cnt_q <= per_cnt_q + 16'd1;
    end
  end

  assign STA_PER_CNT_OUT = per_cnt_q;
`endif

  // Sequencer state plus every output register.
  always_ff @(posedge CLK_IN) begin
    // NOTE: reset is sampled on the clock edge, and all state uses
    // non-blocking assignments so every register samples pre-edge values.
    if (RST_IN) begin
      mode_q     <= MODE_OFF;
      sym_idx_q  <= '0;
      scrm_en_q  <= 1'b0;
      scrm_efm_q <= 1'b0;
      lnk_k_q    <= '0;
      lnk_dat_q  <= '0;
      sta_mode_q <= MODE_OFF;
    end else begin
      mode_q     <= mode_d;
      sym_idx_q  <= sym_idx_d;
      // Leads the data it qualifies by one cycle.
      scrm_en_q  <= (mode_d == MODE_IDLE);
      scrm_efm_q <= CTL_EN_IN;
      if (!CTL_EN_IN) begin
        // Disable blanks the outputs immediately, not after the pipeline.
        lnk_k_q    <= '0;
        lnk_dat_q  <= '0;
        sta_mode_q <= MODE_OFF;
      end else begin
        lnk_k_q    <= pat_k;
        lnk_dat_q  <= pat_dat;
        sta_mode_q <= mode_q;
      end
    end
  end

  assign SCRM_EN_OUT  = scrm_en_q;
  assign SCRM_EFM_OUT = scrm_efm_q;
  assign LNK_K_OUT    = lnk_k_q;
  assign LNK_DAT_OUT  = lnk_dat_q;
  assign STA_MODE_OUT = sta_mode_q;

endmodule

// File: tb/tb_prt_dptx_trn_seq.sv
// -----------------------------------------------------------------------------
// tb_prt_dptx_trn_seq
// Drives one P_SPL=2 instance and one P_SPL=4 instance (both with P_SIM=1)
// from the same stimulus. Every cycle, both are compared against a
// pattern-level reference model. Symbol positions in the model are unbounded
// counts; the pattern tables are indexed modulo their length.
// -----------------------------------------------------------------------------
module tb_prt_dptx_trn_seq;

  localparam int PER = 64;

  localparam logic [7:0] TPS2_D [10] = '{8'hBC, 8'hCB, 8'hBC, 8'hCB, 8'h4A,
                                         8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
  localparam logic [7:0] HDR_D  [7]  = '{8'hBC, 8'hF7, 8'hF7, 8'hBC, 8'h08,
                                         8'h00, 8'h00};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] tps;

  logic        scrm0, efm0, scrm1, efm1;
  logic [1:0]  k0, mode0, mode1;
  logic [3:0]  k1;
  logic [15:0] dat0;
  logic [31:0] dat1;
`ifdef PRT_DPTX_TRN_STAT_EN
  logic [15:0] cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  prt_dptx_trn_seq #(.P_SIM(1), .P_SPL(2)) u_dut2 (
    .CLK_IN       (clk),
    .RST_IN       (rst),
    .CTL_EN_IN    (en),
    .CTL_TPS_IN   (tps),
    .SCRM_EN_OUT  (scrm0),
    .SCRM_EFM_OUT (efm0),
    .LNK_K_OUT    (k0),
    .LNK_DAT_OUT  (dat0),
    .STA_MODE_OUT (mode0)
`ifdef PRT_DPTX_TRN_STAT_EN
    ,
    .STA_PER_CNT_OUT (cnt0)
`endif
  );

  prt_dptx_trn_seq #(.P_SIM(1), .P_SPL(4)) u_dut4 (
    .CLK_IN       (clk),
    .RST_IN       (rst),
    .CTL_EN_IN    (en),
    .CTL_TPS_IN   (tps),
    .SCRM_EN_OUT  (scrm1),
    .SCRM_EFM_OUT (efm1),
    .LNK_K_OUT    (k1),
    .LNK_DAT_OUT  (dat1),
    .STA_MODE_OUT (mode1)
`ifdef PRT_DPTX_TRN_STAT_EN
    ,
    .STA_PER_CNT_OUT (cnt1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance: 0 off, 1 TPS1, 2 TPS2, 3 idle.
  int          spl_of [2] = '{2, 4};
  int          m_mode [2];
  int          m_pos  [2];
  int          m_cnt  [2];
  int          e_mode [2];
  int          e_scrm [2];
  int          e_efm  [2];
  logic [3:0]  e_k    [2];
  logic [31:0] e_dat  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One symbol {k, data} of pattern 'mode' at absolute position 'pos'.
  function automatic logic [8:0] model_sym(input int mode, input int pos);
    int p;
    case (mode)
      1: return {1'b0, 8'h4A};
      2: begin
        p = pos % 10;
        return {TPS2_D[p] == 8'hBC, TPS2_D[p]};
      end
      3: begin
        p = pos % PER;
        if (p < 7) return {p < 4, HDR_D[p]};
        return 9'h000;
      end
      default: return 9'h000;
    endcase
  endfunction

  // Advance instance u's model across one clock edge using the driven inputs.
  task automatic model_step(input int u);
    int req, nm, spl;
    logic [8:0] s;
    spl = spl_of[u];
    if (rst) begin
      e_k[u] = '0; e_dat[u] = '0; e_mode[u] = 0; e_scrm[u] = 0; e_efm[u] = 0;
      m_mode[u] = 0; m_pos[u] = 0; m_cnt[u] = 0;
      return;
    end
    e_k[u] = '0; e_dat[u] = '0; e_mode[u] = 0;
    if (en) begin
      for (int i = 0; i < spl; i++) begin
        s = model_sym(m_mode[u], m_pos[u] + i);
        e_k[u][i] = s[8];
        e_dat[u][8*i +: 8] = s[7:0];
      end
      e_mode[u] = m_mode[u];
    end
    req = (tps == 2'd1) ? 1 : (tps == 2'd2) ? 2 : 3;
    if (!en)                                                nm = 0;
    else if (m_mode[u] == 0)                                nm = req;
    else if (req == m_mode[u])                              nm = m_mode[u];
    else if (m_mode[u] == 2 && (m_pos[u] + spl) % 10 != 0)  nm = 2;
    else                                                    nm = req;
    if (!en) m_cnt[u] = 0;
    else begin
      if (m_mode[u] == 3 && (m_pos[u] + spl) % PER == 0 && m_cnt[u] < 65535) m_cnt[u]++;
      if (nm == 3 && m_mode[u] != 3) m_cnt[u] = 0;
    end
    if (nm != m_mode[u] || nm == 0) m_pos[u] = 0;
    else                            m_pos[u] += spl;
    m_mode[u] = nm;
    e_scrm[u] = (nm == 3);
    e_efm[u]  = en;
  endtask

  task automatic compare_all();
    check("k_spl2",    32'(k0),    32'(e_k[0][1:0]));
    check("dat_spl2",  32'(dat0),  32'(e_dat[0][15:0]));
    check("mode_spl2", 32'(mode0), 32'(e_mode[0]));
    check("scrm_spl2", 32'(scrm0), 32'(e_scrm[0]));
    check("efm_spl2",  32'(efm0),  32'(e_efm[0]));
    check("k_spl4",    32'(k1),    32'(e_k[1]));
    check("dat_spl4",  dat1,       e_dat[1]);
    check("mode_spl4", 32'(mode1), 32'(e_mode[1]));
    check("scrm_spl4", 32'(scrm1), 32'(e_scrm[1]));
    check("efm_spl4",  32'(efm1),  32'(e_efm[1]));
`ifdef PRT_DPTX_TRN_STAT_EN
    check("cnt_spl2",  32'(cnt0),  32'(m_cnt[0]));
    check("cnt_spl4",  32'(cnt1),  32'(m_cnt[1]));
`endif
  endtask

  // Apply inputs away from the edge, clock once, then compare just after it.
  task automatic cycle(input logic r, input logic e, input logic [1:0] t);
    @(negedge clk);
    rst = r; en = e; tps = t;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input logic e, input logic [1:0] t);
    for (int i = 0; i < n; i++) cycle(1'b0, e, t);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tps = 2'd0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'd0);

    // Enable straight into TPS1; D10.2 appears two cycles later.
    run(2, 1'b1, 2'd1);
    check("tps1_first_dat", 32'(dat0), 32'h0000_4A4A);
    check("tps1_first_mode", 32'(mode0), 32'd1);
    run(3, 1'b1, 2'd1);

    // TPS2, then a TPS1 request mid-sequence that must wait for a boundary.
    run(12, 1'b1, 2'd2);
    run(10, 1'b1, 2'd1);

    // Enable into IDLE from OFF: first symbols BS/BF with both k bits set.
    run(1, 1'b0, 2'd0);
    run(1, 1'b1, 2'd0);
    check("idle_scrm_lead", 32'(scrm0), 32'd1);
    check("idle_pre_dat", 32'(dat0), 32'd0);
    run(1, 1'b1, 2'd0);
    check("idle_first_dat", 32'(dat0), 32'h0000_F7BC);
    check("idle_first_k", 32'(k0), 32'd3);
    run(40, 1'b1, 2'd0);

    // Leave IDLE mid-period for TPS1; the reserved code behaves as idle.
    run(6, 1'b1, 2'd1);
    run(20, 1'b1, 2'd3);

    // Drop enable mid-TPS2, then pulse reset in the middle of IDLE.
    run(7, 1'b1, 2'd2);
    run(1, 1'b0, 2'd2);
    run(25, 1'b1, 2'd0);
    cycle(1'b1, 1'b1, 2'd0);
    run(110, 1'b1, 2'd0);
    run(4, 1'b1, 2'd1);
    run(10, 1'b1, 2'd0);

    // Randomized requests, enable drops and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic r, e;
      logic [1:0] t;
      r = ($urandom_range(499) == 0);
      e = ($urandom_range(79) != 0);
      t = tps;
      if ($urandom_range(24) == 0) t = 2'($urandom_range(3));
      cycle(r, e, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
